ctrl_feat_src: RTL and testbench
================================

CTRL_FEAT_SRC -- requirements
Module: ctrl_feat_src

Interface
REQ-001 SHALL have parameter LWIDTH, default 10, the feature-size and counter width.
REQ-002 SHALL have parameter MEMSIZE, default 12, the feature-memory address width.
REQ-003 SHALL have parameter D_MEM, default 2, the feature-memory read latency in cycles (>=1).
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  in  1  start pulse, sampled only in S_WAIT.
REQ-007 SHALL have port fea_size  in  LWIDTH  square feature-map side length.
REQ-008 SHALL have port fea_base  in  MEMSIZE  address of pixel (0,0).
REQ-009 SHALL have port hold  in  1  downstream stall; the read issued in that cycle is suppressed.
REQ-010 SHALL have port busy  out  1  high from the cycle after an accepted req until the return to S_WAIT.
REQ-011 SHALL have port mem_re  out  1  feature-memory read enable.
REQ-012 SHALL have port mem_addr  out  MEMSIZE  feature-memory read address.
REQ-013 SHALL have port out_ctrl  ctrl_bus.out  3 (start, valid, stop)  stream control, aligned with the memory read data.

Function
REQ-014 SHALL use FSM states S_WAIT, S_ACTIVE and S_DRAIN.
REQ-015 SHALL move S_WAIT->S_ACTIVE on req with fea_size!=0, latching fea_size and fea_base; req with fea_size==0 SHALL be ignored.
REQ-016 SHALL, in S_ACTIVE with hold low, assert mem_re and issue one read per cycle in raster order (x fastest, then y).
REQ-017 SHALL advance mem_addr with a running incrementer (no multiplier), wrapping modulo 2^MEMSIZE.
REQ-018 SHALL, while hold is high, freeze the x/y counters and the address, and drive mem_re=0.
REQ-019 SHALL move S_ACTIVE->S_DRAIN on the cycle the last read (x==y==size-1) issues, then S_DRAIN->S_WAIT after exactly D_MEM cycles.
REQ-020 SHALL generate stage-0 flags as follows: start=first read, valid=every issued read, stop=last read.
REQ-021 SHALL delay the stage-0 flags by a D_MEM-deep shift register that is never stalled by hold, so out_ctrl matches the read-data timing.
REQ-022 SHALL assert start, valid and stop in the same output cycle when fea_size==1.
REQ-023 SHALL ignore req while busy and SHALL NOT latch fea_size or fea_base in that case.
REQ-024 SHALL drive mem_re, mem_addr, busy and out_ctrl as registered outputs.

Reset
REQ-025 SHALL, on rst, force S_WAIT, clear counters and address, and drive busy=0, mem_re=0, mem_addr=0 and out_ctrl.start/valid/stop=0.
REQ-026 SHALL flush the delay line on rst mid-frame; no stale valid or stop SHALL appear after reset.
REQ-027 SHALL accept a new req in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL use macro RENKON_FEAT_PAD_EN to add a zero-padding border.
REQ-029 With RENKON_FEAT_PAD_EN defined:
- traversal SHALL cover (fea_size+2)^2 positions;
- border positions SHALL produce valid with mem_re=0 and SHALL NOT advance the address;
- extra output pad_oe (out, 1 bit, D_MEM-delayed) SHALL mark border valids so downstream substitutes zero;
- start and stop SHALL mark the first and last padded positions.
REQ-030 Without RENKON_FEAT_PAD_EN, the pad_oe port and the padding logic SHALL be absent and behaviour SHALL be per REQ-016..REQ-023.

Verification
REQ-031 fea_size=3, fea_base=0x010, D_MEM=2, hold=0 -> mem_addr 0x010..0x018 on 9 consecutive cycles; out_ctrl.start 2 cycles after the first read; 9 contiguous valids; stop on the 9th valid; busy low 2 cycles after the last read.
REQ-032 Same setup, hold high for 3 cycles at the 4th pixel -> address held at 0x013 with mem_re=0; a 3-cycle valid gap; 9 valids total over 12 cycles.
REQ-033 fea_size=1, fea_base=0xFFF (MEMSIZE=12) -> single read at 0xFFF; start, valid and stop coincide; return to S_WAIT after D_MEM cycles.
REQ-034 req with fea_size=0 -> no busy and no reads; req pulsed mid-frame -> no effect on the address sequence.
REQ-035 rst at the 5th read of a fea_size=4 frame -> all outputs 0 the next cycle and no later valid; a following req with fea_size=2 yields exactly 4 valids.
REQ-036 RENKON_FEAT_PAD_EN, fea_size=2, fea_base=0 -> 16 valids; pad_oe on the 12 border valids; mem_re 4 times at addresses 0..3.

Source files
------------

// File: rtl/ctrl_feat_src_if.sv
// Stream control bundle (start, valid, stop) travelling with feature-memory read data.
interface ctrl_bus;
   logic start;
   logic valid;
   logic stop;
   modport out (output start, valid, stop);
   modport mon (input start, valid, stop);
endinterface

// File: rtl/ctrl_feat_src.sv
// Raster-order feature-map read sequencer with read-aligned stream control.
// Optional zero-padding border: define RENKON_FEAT_PAD_EN (adds pad_oe).
module ctrl_feat_src #(
   parameter int LWIDTH  = 10,
   parameter int MEMSIZE = 12,
   parameter int D_MEM   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic [LWIDTH-1:0]  fea_size,
   input  logic [MEMSIZE-1:0] fea_base,
   input  logic               hold,
   output logic               busy,
   output logic               mem_re,
   output logic [MEMSIZE-1:0] mem_addr,
   ctrl_bus.out               out_ctrl
`ifdef RENKON_FEAT_PAD_EN
   ,
   output logic               pad_oe
`endif
);
   localparam int CW = LWIDTH + 1;
   localparam int DW = $clog2(D_MEM + 1);

   typedef enum logic [1:0] {
      S_WAIT,
      S_ACTIVE,
      S_DRAIN
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      x_q, y_q, lim_q;
   logic [MEMSIZE-1:0] addr_q, mem_addr_q;
   logic [DW-1:0]      dcnt_q;
   logic               busy_q, mem_re_q;
   logic [D_MEM:0]     st_q, vl_q, sp_q;

   logic x_end, y_end, first, last;
   logic issue, border, rd;

   assign x_end  = (x_q == lim_q);
   assign y_end  = (y_q == lim_q);
   assign first  = (x_q == '0) && (y_q == '0);
   assign last   = x_end && y_end;
   assign issue  = (state_q == S_ACTIVE) && !hold;
`ifdef RENKON_FEAT_PAD_EN
   assign border = (x_q == '0) || (y_q == '0) || x_end || y_end;
`else
   assign border = 1'b0;
`endif
   assign rd     = issue && !border;

`ifdef RENKON_FEAT_PAD_EN
   logic [D_MEM:0] pd_q;
   always_ff @(posedge clk) begin
      if (rst) pd_q <= '0;
      else     pd_q <= {pd_q[D_MEM-1:0], issue & border};
   end
   assign pad_oe = pd_q[D_MEM];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_WAIT;
         x_q        <= '0;
         y_q        <= '0;
         lim_q      <= '0;
         addr_q     <= '0;
         dcnt_q     <= '0;
         busy_q     <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_addr_q <= '0;
         st_q       <= '0;
         vl_q       <= '0;
         sp_q       <= '0;
      end else begin
         // Flag pipe never stalls: stage 0 is aligned with mem_re
         st_q     <= {st_q[D_MEM-1:0], issue & first};
         vl_q     <= {vl_q[D_MEM-1:0], issue};
         sp_q     <= {sp_q[D_MEM-1:0], issue & last};
         mem_re_q <= rd;
         case (state_q)
            S_WAIT: begin
               if (req && (fea_size != '0)) begin
                  state_q <= S_ACTIVE;
                  busy_q  <= 1'b1;
                  x_q     <= '0;
                  y_q     <= '0;
                  addr_q  <= fea_base;
`ifdef RENKON_FEAT_PAD_EN
                  lim_q   <= CW'(fea_size) + CW'(1);
`else
                  lim_q   <= CW'(fea_size) - CW'(1);
`endif
               end
            end
            S_ACTIVE: begin
               mem_addr_q <= addr_q;
               if (issue) begin
                  if (rd) addr_q <= addr_q + MEMSIZE'(1);
                  if (last) begin
                     state_q <= S_DRAIN;
                     dcnt_q  <= DW'(D_MEM - 1);
                  end else if (x_end) begin
                     x_q <= '0;
                     y_q <= y_q + CW'(1);
                  end else begin
                     x_q <= x_q + CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (dcnt_q == '0) begin
                  state_q <= S_WAIT;
                  busy_q  <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q - DW'(1);
               end
            end
            default: state_q <= S_WAIT;
         endcase
      end
   end

   assign busy           = busy_q;
   assign mem_re         = mem_re_q;
   assign mem_addr       = mem_addr_q;
   assign out_ctrl.start = st_q[D_MEM];
   assign out_ctrl.valid = vl_q[D_MEM];
   assign out_ctrl.stop  = sp_q[D_MEM];
endmodule

// File: tb/tb_ctrl_feat_src.sv
// Directed self-checking bench for ctrl_feat_src (D_MEM=2, MEMSIZE=12).
module tb_ctrl_feat_src;
   logic        clk;
   logic        rst;
   logic        req;
   logic [9:0]  fea_size;
   logic [11:0] fea_base;
   logic        hold;
   logic        busy;
   logic        mem_re;
   logic [11:0] mem_addr;
`ifdef RENKON_FEAT_PAD_EN
   logic        pad_oe;
`endif
   int n_chk;
   int n_fail;

   ctrl_bus cb ();

   ctrl_feat_src #(.LWIDTH(10), .MEMSIZE(12), .D_MEM(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .fea_size (fea_size),
      .fea_base (fea_base),
      .hold     (hold),
      .busy     (busy),
      .mem_re   (mem_re),
      .mem_addr (mem_addr),
      .out_ctrl (cb)
`ifdef RENKON_FEAT_PAD_EN
      ,
      .pad_oe   (pad_oe)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not reach summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] got;
      rst = 1'b1;
      repeat (3) step();
      got = {busy, mem_re, mem_addr, cb.start, cb.valid, cb.stop};
      n_chk++;
      if (got !== 17'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=0", got);
      end
      rst = 1'b0;
      // accept in first cycle after reset release
      req = 1'b1; fea_size = 10'd1; fea_base = 12'h000;
      step();
      req = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL req_after_rst busy=%b exp=1", busy);
      end
      repeat (6) step();
   endtask

   task automatic test_basic();
      logic [4:0] got, exp;
      logic er;
      req = 1'b1; fea_size = 10'd3; fea_base = 12'h010;
      step();
      req = 1'b0;
      for (int c = 0; c < 16; c++) begin
         step();
         er  = (c <= 8);
         exp = {c <= 9, er, c == 2, (c >= 2) && (c <= 10), c == 10};
         got = {busy, mem_re, cb.start, cb.valid, cb.stop};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL basic_ctrl c=%0d got=%b exp=%b", c, got, exp);
         end
         if (er) begin
            n_chk++;
            if (mem_addr !== 12'(16 + c)) begin
               n_fail++;
               $display("FAIL basic_addr c=%0d got=%h exp=%h",
                        c, mem_addr, 12'(16 + c));
            end
         end
      end
   endtask

   task automatic test_hold();
      logic [4:0] got, exp;
      logic [11:0] ea;
      logic er;
      int vcnt;
      vcnt = 0;
      req = 1'b1; fea_size = 10'd3; fea_base = 12'h010;
      step();
      req = 1'b0;
      for (int c = 0; c < 16; c++) begin
         hold = (c >= 3) && (c <= 5);
         step();
         er  = (c <= 2) || ((c >= 6) && (c <= 11));
         exp = {c <= 12, er, c == 2,
                ((c >= 2) && (c <= 4)) || ((c >= 8) && (c <= 13)), c == 13};
         got = {busy, mem_re, cb.start, cb.valid, cb.stop};
         if (cb.valid === 1'b1) vcnt++;
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL hold_ctrl c=%0d got=%b exp=%b", c, got, exp);
         end
         if (c <= 11) begin
            ea = (c <= 2) ? 12'(16 + c) :
                 (c <= 5) ? 12'h013 : 12'(19 + c - 6);
            n_chk++;
            if (mem_addr !== ea) begin
               n_fail++;
               $display("FAIL hold_addr c=%0d got=%h exp=%h", c, mem_addr, ea);
            end
         end
      end
      hold = 1'b0;
      n_chk++;
      if (vcnt != 9) begin
         n_fail++;
         $display("FAIL hold_vcount got=%0d exp=9", vcnt);
      end
   endtask

   task automatic test_size1_wrap();
      logic [4:0] got, exp;
      req = 1'b1; fea_size = 10'd1; fea_base = 12'hFFF;
      step();
      req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         exp = {c <= 1, c == 0, c == 2, c == 2, c == 2};
         got = {busy, mem_re, cb.start, cb.valid, cb.stop};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL size1_ctrl c=%0d got=%b exp=%b", c, got, exp);
         end
         if (c == 0) begin
            n_chk++;
            if (mem_addr !== 12'hFFF) begin
               n_fail++;
               $display("FAIL size1_addr got=%h exp=fff", mem_addr);
            end
         end
      end
   endtask

   task automatic test_zero_size();
      req = 1'b1; fea_size = 10'd0; fea_base = 12'h055;
      step();
      req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         n_chk++;
         if ({busy, mem_re, cb.valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_size c=%0d busy=%b re=%b valid=%b exp=000",
                     c, busy, mem_re, cb.valid);
         end
      end
   endtask

   task automatic test_req_while_busy();
      logic [1:0] got, exp;
      req = 1'b1; fea_size = 10'd3; fea_base = 12'h100;
      step();
      req = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (c == 4) begin
            req = 1'b1; fea_size = 10'd5; fea_base = 12'h200;
         end else begin
            req = 1'b0;
         end
         step();
         exp = {c <= 9, c <= 8};
         got = {busy, mem_re};
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL midreq_ctrl c=%0d got=%b exp=%b", c, got, exp);
         end
         if (c <= 8) begin
            n_chk++;
            if (mem_addr !== 12'(256 + c)) begin
               n_fail++;
               $display("FAIL midreq_addr c=%0d got=%h exp=%h",
                        c, mem_addr, 12'(256 + c));
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [16:0] got;
      logic [4:0]  g5, e5;
      int vcnt;
      vcnt = 0;
      req = 1'b1; fea_size = 10'd4; fea_base = 12'h040;
      step();
      req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         n_chk++;
         if ({mem_re, mem_addr} !== {1'b1, 12'(64 + c)}) begin
            n_fail++;
            $display("FAIL rstmid_pre c=%0d re=%b addr=%h exp=1 %h",
                     c, mem_re, mem_addr, 12'(64 + c));
         end
      end
      rst = 1'b1;
      step();
      got = {busy, mem_re, mem_addr, cb.start, cb.valid, cb.stop};
      n_chk++;
      if (got !== 17'h0) begin
         n_fail++;
         $display("FAIL rstmid_zero got=%h exp=0", got);
      end
      rst = 1'b0;
      req = 1'b1; fea_size = 10'd2; fea_base = 12'h020;
      step();
      req = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (cb.valid === 1'b1) vcnt++;
         e5 = {c <= 4, c <= 3, c == 2, (c >= 2) && (c <= 5), c == 5};
         g5 = {busy, mem_re, cb.start, cb.valid, cb.stop};
         n_chk++;
         if (g5 !== e5) begin
            n_fail++;
            $display("FAIL rstmid_frame c=%0d got=%b exp=%b", c, g5, e5);
         end
         if (c <= 3) begin
            n_chk++;
            if (mem_addr !== 12'(32 + c)) begin
               n_fail++;
               $display("FAIL rstmid_addr c=%0d got=%h exp=%h",
                        c, mem_addr, 12'(32 + c));
            end
         end
      end
      n_chk++;
      if (vcnt != 4) begin
         n_fail++;
         $display("FAIL rstmid_vcount got=%0d exp=4", vcnt);
      end
   endtask

`ifdef RENKON_FEAT_PAD_EN
   task automatic test_pad();
      logic [5:0] got, exp;
      logic bd, ein, pe;
      int k, vcnt, pcnt, rcnt, x, y;
      k = 0; vcnt = 0; pcnt = 0; rcnt = 0;
      req = 1'b1; fea_size = 10'd2; fea_base = 12'h000;
      step();
      req = 1'b0;
      for (int c = 0; c < 21; c++) begin
         step();
         x   = c % 4;
         y   = c / 4;
         ein = (c < 16) && (x >= 1) && (x <= 2) && (y >= 1) && (y <= 2);
         x   = (c - 2) % 4;
         y   = (c - 2) / 4;
         bd  = (x == 0) || (x == 3) || (y == 0) || (y == 3);
         pe  = (c >= 2) && (c <= 17) && bd;
         exp = {c <= 16, ein, c == 2, (c >= 2) && (c <= 17), c == 17, pe};
         got = {busy, mem_re, cb.start, cb.valid, cb.stop, pad_oe};
         if (cb.valid === 1'b1) vcnt++;
         if (pad_oe === 1'b1) pcnt++;
         if (mem_re === 1'b1) rcnt++;
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL pad_ctrl c=%0d got=%b exp=%b", c, got, exp);
         end
         if (ein) begin
            n_chk++;
            if (mem_addr !== 12'(k)) begin
               n_fail++;
               $display("FAIL pad_addr c=%0d got=%h exp=%h", c, mem_addr, 12'(k));
            end
            k++;
         end
      end
      n_chk++;
      if ({vcnt, pcnt, rcnt} != {32'd16, 32'd12, 32'd4}) begin
         n_fail++;
         $display("FAIL pad_counts valid=%0d pad=%0d re=%0d exp=16 12 4",
                  vcnt, pcnt, rcnt);
      end
   endtask
`endif

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      req = 1'b0;
      fea_size = '0;
      fea_base = '0;
      hold = 1'b0;
      test_reset();
`ifdef RENKON_FEAT_PAD_EN
      test_pad();
`else
      test_basic();
      test_hold();
      test_size1_wrap();
      test_zero_size();
      test_req_while_busy();
      test_reset_mid_frame();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
